// File: rtl/mem_rr_arbiter_if.sv
// Bundle of the requester-side and downstream mem-protocol signals around
// mem_rr_arbiter. The arbiter connects through the slave modport, and the
// surrounding environment drives it through the master modport.
interface mem_rr_arbiter_if #(
   parameter int NUM_REQ        = 2,
   parameter int MEM_ADDR_WIDTH = 32,
   parameter int MEM_DATA_WIDTH = 32
);
   localparam int BE_WIDTH = MEM_DATA_WIDTH / 8;

   // Requester side
   logic [NUM_REQ-1:0]                req_i;
   logic [NUM_REQ*MEM_ADDR_WIDTH-1:0] addr_i;
   logic [NUM_REQ-1:0]                we_i;
   logic [NUM_REQ*MEM_DATA_WIDTH-1:0] wdata_i;
   logic [NUM_REQ*BE_WIDTH-1:0]       be_i;
   logic [NUM_REQ-1:0]                gnt_o;
   logic [NUM_REQ-1:0]                rsp_valid_o;
   logic [MEM_DATA_WIDTH-1:0]         rsp_rdata_o;
   logic                              rsp_error_o;

   // Downstream side
   logic                              mem_req_o;
   logic [MEM_ADDR_WIDTH-1:0]         mem_addr_o;
   logic                              mem_we_o;
   logic [MEM_DATA_WIDTH-1:0]         mem_wdata_o;
   logic [BE_WIDTH-1:0]               mem_be_o;
   logic                              mem_gnt_i;
   logic                              mem_rsp_valid_i;
   logic [MEM_DATA_WIDTH-1:0]         mem_rsp_rdata_i;
   logic                              mem_rsp_error_i;

   // Status
   logic                              spurious_rsp_o;
   logic [31:0]                       stall_cnt_o;

   modport slave (
      input  req_i, addr_i, we_i, wdata_i, be_i,
      input  mem_gnt_i, mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_error_i,
      output gnt_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
      output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o,
      output spurious_rsp_o, stall_cnt_o
   );

   modport master (
      output req_i, addr_i, we_i, wdata_i, be_i,
      output mem_gnt_i, mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_error_i,
      input  gnt_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
      input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o,
      input  spurious_rsp_o, stall_cnt_o
   );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter that shares one downstream mem-protocol port between
// NUM_REQ requesters. Once a requester is presented downstream without a grant,
// the selection is frozen until the grant arrives, which keeps the bridge
// request stable. An in-order ID FIFO routes each response back to the
// requester that issued it.
// Optional build macro MEM_RR_ARBITER_STALL_CNT_EN adds a saturating 32-bit
// stall counter. Without it, stall_cnt_o is tied to zero.
module mem_rr_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int MEM_ADDR_WIDTH  = 32,
   parameter int MEM_DATA_WIDTH  = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int IDX_WIDTH       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input logic             clk_i,
   input logic             rst_i,
   mem_rr_arbiter_if.slave bus
);
   localparam int BE_WIDTH = MEM_DATA_WIDTH / 8;
   localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_REQ - 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t               state, state_nxt;
   logic [IDX_WIDTH-1:0] prio, prio_nxt;
   logic [IDX_WIDTH-1:0] lock_idx, lock_idx_nxt;
   logic [IDX_WIDTH-1:0] rr_idx, cand, sel, head;
   logic                 rr_found, sel_valid;
   logic                 mem_req, push, pop, spurious;
   logic [IDX_WIDTH-1:0] id_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     count;

   // The FIFO depth is not necessarily a power of two, so wrap explicitly.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Pick the first active requester, starting at the priority pointer.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_WIDTH'((int'(prio) + k) % NUM_REQ);
         if (!rr_found && bus.req_i[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end
      end
   end

   // Lock FSM. A full FIFO suppresses mem_req, so the lock state is left unchanged.
   always_comb begin
      state_nxt    = state;
      prio_nxt     = prio;
      lock_idx_nxt = lock_idx;
      sel          = rr_idx;
      sel_valid    = rr_found;
      if (state == LOCKED) begin
         sel       = lock_idx;
         sel_valid = 1'b1;
      end
      mem_req = sel_valid && (count < CNT_FULL) && !rst_i;
      push    = mem_req && bus.mem_gnt_i;
      if (push) begin
         state_nxt = IDLE;
         prio_nxt  = (sel == IDX_LAST) ? '0 : sel + 1'b1;
      end else if (mem_req) begin
         state_nxt    = LOCKED;
         lock_idx_nxt = sel;
      end
   end

   // Arbitration state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         prio     <= '0;
         lock_idx <= '0;
      end else begin
         state    <= state_nxt;
         prio     <= prio_nxt;
         lock_idx <= lock_idx_nxt;
      end
   end

   assign head = id_fifo[rd_ptr];
   assign pop  = bus.mem_rsp_valid_i && (count != '0) && !rst_i;

   // ID FIFO pointers and occupancy. A simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ID FIFO storage. This holds only data, so it has no reset.
   always_ff @(posedge clk_i) begin
      if (push) id_fifo[wr_ptr] <= sel;
   end

   // Sticky flag for a response that arrives with nothing outstanding.
   always_ff @(posedge clk_i) begin
      if (rst_i)                                        spurious <= 1'b0;
      else if (bus.mem_rsp_valid_i && (count == '0))    spurious <= 1'b1;
   end

   // Per-requester grant and response-valid decode.
   always_comb begin
      bus.gnt_o       = '0;
      bus.rsp_valid_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.gnt_o[i]       = push && (sel == IDX_WIDTH'(i));
         bus.rsp_valid_o[i] = pop && (head == IDX_WIDTH'(i));
      end
   end

   // The downstream payload mux follows the selected requester.
   always_comb begin
      bus.mem_addr_o  = '0;
      bus.mem_we_o    = 1'b0;
      bus.mem_wdata_o = '0;
      bus.mem_be_o    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == IDX_WIDTH'(i)) begin
            bus.mem_addr_o  = bus.addr_i[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
            bus.mem_we_o    = bus.we_i[i];
            bus.mem_wdata_o = bus.wdata_i[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
            bus.mem_be_o    = bus.be_i[i*BE_WIDTH +: BE_WIDTH];
         end
      end
   end

   assign bus.mem_req_o      = mem_req;
   assign bus.rsp_rdata_o    = bus.mem_rsp_rdata_i;
   assign bus.rsp_error_o    = bus.mem_rsp_error_i;
   assign bus.spurious_rsp_o = spurious;

`ifdef MEM_RR_ARBITER_STALL_CNT_EN
   logic [31:0] stall_cnt;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   // Count cycles where someone is waiting and no handshake completes.
   always_ff @(posedge clk_i) begin
      if (rst_i)                        stall_cnt <= '0;
      else if (|bus.req_i && !push)     stall_cnt <= sat_inc(stall_cnt);
   end

   assign bus.stall_cnt_o = stall_cnt;
`else
   assign bus.stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios followed by randomized traffic
// checked against a queue-based reference model of the arbitration rules.
module tb_mem_rr_arbiter;
   localparam int N    = 2;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int BW   = DW / 8;
   localparam int MAXO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mem_rr_arbiter_if #(.NUM_REQ(N), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) bus ();

   mem_rr_arbiter #(
      .NUM_REQ(N), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_i           = '0;
      bus.addr_i          = '0;
      bus.we_i            = '0;
      bus.wdata_i         = '0;
      bus.be_i            = '0;
      bus.mem_gnt_i       = 1'b0;
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rsp_rdata_i = '0;
      bus.mem_rsp_error_i = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      bus.req_i = 2'b11; bus.mem_gnt_i = 1'b1; bus.mem_rsp_valid_i = 1'b1;
      #2;
      n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got=%0b exp=0", bus.mem_req_o); end
      n_cmp++; if (bus.gnt_o !== 2'b00) begin n_err++; $display("FAIL reset_gnt got=%b exp=00", bus.gnt_o); end
      n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid_o); end
      step(); step();
      clear_inputs();
      rst = 1'b0;
      #2;
      n_cmp++; if (bus.spurious_rsp_o !== 1'b0) begin n_err++; $display("FAIL reset_spurious got=%0b exp=0", bus.spurious_rsp_o); end
      n_cmp++; if (bus.stall_cnt_o !== 32'd0) begin n_err++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cnt_o); end
      n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL idle_mem_req got=%0b exp=0", bus.mem_req_o); end
      step();
   endtask

   task automatic test_basic();
      apply_reset();
      bus.req_i = 2'b01; bus.addr_i[0 +: AW] = 32'h1000; bus.mem_gnt_i = 1'b1;
      #2;
      n_cmp++; if (bus.mem_req_o !== 1'b1) begin n_err++; $display("FAIL basic_mem_req got=%0b exp=1", bus.mem_req_o); end
      n_cmp++; if (bus.mem_addr_o !== 32'h1000) begin n_err++; $display("FAIL basic_addr got=%h exp=00001000", bus.mem_addr_o); end
      n_cmp++; if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL basic_gnt got=%b exp=01", bus.gnt_o); end
      step();
      bus.req_i = 2'b00; bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_rdata_i = 32'hDEADBEEF;
      #2;
      n_cmp++; if (bus.rsp_valid_o !== 2'b01) begin n_err++; $display("FAIL basic_rsp_valid got=%b exp=01", bus.rsp_valid_o); end
      n_cmp++; if (bus.rsp_rdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_rdata got=%h exp=deadbeef", bus.rsp_rdata_o); end
      step();
      clear_inputs();
   endtask

   task automatic test_fairness();
      logic [1:0]  seq [4];
      logic [31:0] adr [4];
      seq = '{2'b01, 2'b10, 2'b01, 2'b10};
      adr = '{32'hA0, 32'hB0, 32'hA0, 32'hB0};
      apply_reset();
      bus.req_i = 2'b11; bus.addr_i = {32'hB0, 32'hA0}; bus.mem_gnt_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #2;
         n_cmp++; if (bus.gnt_o !== seq[c]) begin n_err++; $display("FAIL fair_gnt[%0d] got=%b exp=%b", c, bus.gnt_o, seq[c]); end
         n_cmp++; if (bus.mem_addr_o !== adr[c]) begin n_err++; $display("FAIL fair_addr[%0d] got=%h exp=%h", c, bus.mem_addr_o, adr[c]); end
         step();
      end
      bus.req_i = 2'b00; bus.mem_rsp_valid_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         bus.mem_rsp_rdata_i = 32'h100 + 32'(c);
         #2;
         n_cmp++; if (bus.rsp_valid_o !== seq[c]) begin n_err++; $display("FAIL fair_rsp[%0d] got=%b exp=%b", c, bus.rsp_valid_o, seq[c]); end
         step();
      end
      clear_inputs();
   endtask

   task automatic test_lock();
      apply_reset();
      bus.req_i = 2'b01; bus.addr_i = {32'h3000, 32'h2000}; bus.mem_gnt_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) bus.req_i = 2'b11;
         #2;
         n_cmp++; if (bus.mem_addr_o !== 32'h2000) begin n_err++; $display("FAIL lock_addr[%0d] got=%h exp=00002000", c, bus.mem_addr_o); end
         n_cmp++; if (bus.gnt_o !== 2'b00) begin n_err++; $display("FAIL lock_gnt[%0d] got=%b exp=00", c, bus.gnt_o); end
         step();
      end
      bus.mem_gnt_i = 1'b1;
      #2;
      n_cmp++; if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL lock_release_gnt got=%b exp=01", bus.gnt_o); end
      n_cmp++; if (bus.mem_addr_o !== 32'h2000) begin n_err++; $display("FAIL lock_release_addr got=%h exp=00002000", bus.mem_addr_o); end
      step();
      bus.req_i = 2'b10;
      #2;
      n_cmp++; if (bus.gnt_o !== 2'b10) begin n_err++; $display("FAIL lock_next_gnt got=%b exp=10", bus.gnt_o); end
      n_cmp++; if (bus.mem_addr_o !== 32'h3000) begin n_err++; $display("FAIL lock_next_addr got=%h exp=00003000", bus.mem_addr_o); end
      step();
      bus.req_i = 2'b00; bus.mem_rsp_valid_i = 1'b1;
      #2;
      n_cmp++; if (bus.rsp_valid_o !== 2'b01) begin n_err++; $display("FAIL lock_rsp0 got=%b exp=01", bus.rsp_valid_o); end
      step();
      #2;
      n_cmp++; if (bus.rsp_valid_o !== 2'b10) begin n_err++; $display("FAIL lock_rsp1 got=%b exp=10", bus.rsp_valid_o); end
      step();
      clear_inputs();
   endtask

   task automatic test_full();
      apply_reset();
      bus.req_i = 2'b01; bus.addr_i[0 +: AW] = 32'h4000; bus.mem_gnt_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #2;
         n_cmp++; if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL full_fill_gnt[%0d] got=%b exp=01", c, bus.gnt_o); end
         step();
      end
      #2;
      n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL full_block_req got=%0b exp=0", bus.mem_req_o); end
      n_cmp++; if (bus.gnt_o !== 2'b00) begin n_err++; $display("FAIL full_block_gnt got=%b exp=00", bus.gnt_o); end
      step();
      bus.mem_rsp_valid_i = 1'b1;
      #2;
      n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL full_pop_same_cycle_req got=%0b exp=0", bus.mem_req_o); end
      n_cmp++; if (bus.rsp_valid_o !== 2'b01) begin n_err++; $display("FAIL full_pop_rsp got=%b exp=01", bus.rsp_valid_o); end
      step();
      bus.mem_rsp_valid_i = 1'b0;
      #2;
      n_cmp++; if (bus.mem_req_o !== 1'b1) begin n_err++; $display("FAIL full_after_pop_req got=%0b exp=1", bus.mem_req_o); end
      n_cmp++; if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL full_after_pop_gnt got=%b exp=01", bus.gnt_o); end
      step();
      bus.mem_rsp_valid_i = 1'b1;
      #2;
      n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL full_again_req got=%0b exp=0", bus.mem_req_o); end
      step();
      #2;
      n_cmp++; if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL pushpop_gnt got=%b exp=01", bus.gnt_o); end
      n_cmp++; if (bus.rsp_valid_o !== 2'b01) begin n_err++; $display("FAIL pushpop_rsp got=%b exp=01", bus.rsp_valid_o); end
      step();
      bus.mem_rsp_valid_i = 1'b0;
      #2;
      n_cmp++; if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL pushpop_count_gnt got=%b exp=01", bus.gnt_o); end
      step();
      #2;
      n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL pushpop_refull_req got=%0b exp=0", bus.mem_req_o); end
      step();
      clear_inputs();
   endtask

   task automatic test_spurious_reset();
      apply_reset();
      bus.mem_rsp_valid_i = 1'b1;
      #2;
      n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_err++; $display("FAIL spur_rsp_valid got=%b exp=00", bus.rsp_valid_o); end
      step();
      bus.mem_rsp_valid_i = 1'b0;
      #2;
      n_cmp++; if (bus.spurious_rsp_o !== 1'b1) begin n_err++; $display("FAIL spur_flag got=%0b exp=1", bus.spurious_rsp_o); end
      bus.req_i = 2'b01; bus.mem_gnt_i = 1'b1;
      step(); step();
      rst = 1'b1; bus.mem_rsp_valid_i = 1'b1;
      #2;
      n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL midrst_mem_req got=%0b exp=0", bus.mem_req_o); end
      n_cmp++; if (bus.gnt_o !== 2'b00) begin n_err++; $display("FAIL midrst_gnt got=%b exp=00", bus.gnt_o); end
      n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_err++; $display("FAIL midrst_rsp got=%b exp=00", bus.rsp_valid_o); end
      step();
      #2;
      n_cmp++; if (bus.spurious_rsp_o !== 1'b0) begin n_err++; $display("FAIL midrst_spur got=%0b exp=0", bus.spurious_rsp_o); end
      rst = 1'b0; bus.req_i = 2'b00; bus.mem_gnt_i = 1'b0;
      #1;
      n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_err++; $display("FAIL stale_rsp got=%b exp=00", bus.rsp_valid_o); end
      step();
      bus.mem_rsp_valid_i = 1'b0;
      #2;
      n_cmp++; if (bus.spurious_rsp_o !== 1'b1) begin n_err++; $display("FAIL stale_spur got=%0b exp=1", bus.spurious_rsp_o); end
      step();
      clear_inputs();
   endtask

   task automatic test_stall();
      logic [31:0] exp_stall;
`ifdef MEM_RR_ARBITER_STALL_CNT_EN
      exp_stall = 32'd5;
`else
      exp_stall = 32'd0;
`endif
      apply_reset();
      bus.req_i = 2'b01; bus.mem_gnt_i = 1'b0;
      for (int c = 0; c < 5; c++) step();
      bus.mem_gnt_i = 1'b1;
      #2;
      n_cmp++; if (bus.gnt_o !== 2'b01) begin n_err++; $display("FAIL stall_gnt got=%b exp=01", bus.gnt_o); end
      step();
      bus.req_i = 2'b00; bus.mem_gnt_i = 1'b0;
      #2;
      n_cmp++; if (bus.stall_cnt_o !== exp_stall) begin n_err++; $display("FAIL stall_cnt got=%0d exp=%0d", bus.stall_cnt_o, exp_stall); end
      step();
      clear_inputs();
   endtask

   task automatic test_random();
      int          q[$];
      int          ptr, lock, sel;
      bit          sel_ok, mreq, hs;
      bit          pend [N];
      logic [AW-1:0] a [N];
      logic [DW-1:0] d [N];
      logic [BW-1:0] b [N];
      logic          w [N];
      logic [N-1:0]  eg, er;
      logic [DW-1:0] rd;
      logic          re;
      apply_reset();
      ptr = 0; lock = -1;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(1, 0) == 1) begin
               pend[i] = 1'b1;
               a[i] = $urandom; d[i] = $urandom; b[i] = BW'($urandom); w[i] = 1'($urandom);
            end
            bus.req_i[i]            = pend[i];
            bus.addr_i[i*AW +: AW]  = a[i];
            bus.wdata_i[i*DW +: DW] = d[i];
            bus.be_i[i*BW +: BW]    = b[i];
            bus.we_i[i]             = w[i];
         end
         bus.mem_gnt_i       = ($urandom_range(3, 0) != 0);
         bus.mem_rsp_valid_i = (q.size() > 0) && ($urandom_range(2, 0) == 0);
         rd = $urandom; re = 1'($urandom);
         bus.mem_rsp_rdata_i = rd; bus.mem_rsp_error_i = re;
         sel_ok = 1'b0; sel = 0;
         if (lock >= 0) begin
            sel = lock; sel_ok = 1'b1;
         end else begin
            for (int k = 0; k < N; k++)
               if (!sel_ok && pend[(ptr + k) % N]) begin sel = (ptr + k) % N; sel_ok = 1'b1; end
         end
         mreq = sel_ok && (q.size() < MAXO);
         hs   = mreq && bus.mem_gnt_i;
         eg = '0; if (hs) eg[sel] = 1'b1;
         er = '0; if (bus.mem_rsp_valid_i) er[q[0]] = 1'b1;
         #2;
         n_cmp++; if (bus.mem_req_o !== mreq) begin n_err++; $display("FAIL rnd_mem_req c=%0d got=%0b exp=%0b", c, bus.mem_req_o, mreq); end
         n_cmp++; if (bus.gnt_o !== eg) begin n_err++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, bus.gnt_o, eg); end
         n_cmp++; if (bus.rsp_valid_o !== er) begin n_err++; $display("FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, bus.rsp_valid_o, er); end
         n_cmp++; if (bus.rsp_rdata_o !== rd || bus.rsp_error_o !== re) begin n_err++; $display("FAIL rnd_rsp_data c=%0d got=%h/%0b exp=%h/%0b", c, bus.rsp_rdata_o, bus.rsp_error_o, rd, re); end
         if (mreq) begin
            n_cmp++;
            if (bus.mem_addr_o !== a[sel] || bus.mem_wdata_o !== d[sel] || bus.mem_be_o !== b[sel] || bus.mem_we_o !== w[sel]) begin
               n_err++;
               $display("FAIL rnd_payload c=%0d got=%h/%h/%h/%0b exp=%h/%h/%h/%0b", c, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o, bus.mem_we_o, a[sel], d[sel], b[sel], w[sel]);
            end
         end
         n_cmp++; if (bus.spurious_rsp_o !== 1'b0) begin n_err++; $display("FAIL rnd_spur c=%0d got=%0b exp=0", c, bus.spurious_rsp_o); end
         step();
         if (bus.mem_rsp_valid_i) void'(q.pop_front());
         if (hs) begin
            q.push_back(sel); ptr = (sel + 1) % N; lock = -1; pend[sel] = 1'b0;
         end else if (mreq) begin
            lock = sel;
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_basic();
      test_fairness();
      test_lock();
      test_full();
      test_spurious_reset();
      test_stall();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached got=running exp=finished");
      $fatal(1, "watchdog");
   end
endmodule
